// File: rtl/acc_pkg.sv
// Shared opcodes and FSM state encoding for the accumulator unit.
package acc_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_CLR = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

endpackage

// File: rtl/acc_alu.sv
// Single-cycle ALU: new accumulator value plus carry/borrow and signed overflow.
module acc_alu
  import acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LOAD_W = 5
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] opr,
  input  logic [3:0]        op_code,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              v
);

  localparam int MSB = DATA_W - 1;
  // Built one bit wider so LOAD_W == DATA_W still yields an all-ones mask.
  localparam logic [DATA_W:0] LD_MASK_X = ((DATA_W+1)'(1) << LOAD_W) - (DATA_W+1)'(1);

  logic [DATA_W:0] ext;

  always_comb begin
    result = acc;
    c      = 1'b0;
    v      = 1'b0;
    ext    = '0;
    case (op_code)
      OP_LD:  result = opr & LD_MASK_X[DATA_W-1:0];
      OP_ADD: begin
        ext    = {1'b0, acc} + {1'b0, opr};
        result = ext[MSB:0];
        c      = ext[DATA_W];
        v      = (acc[MSB] == opr[MSB]) && (result[MSB] != acc[MSB]);
      end
      OP_SUB: begin
        ext    = {1'b0, acc} - {1'b0, opr};
        result = ext[MSB:0];
        c      = ext[DATA_W];
        v      = (acc[MSB] != opr[MSB]) && (result[MSB] != acc[MSB]);
      end
      OP_AND: result = acc & opr;
      OP_OR:  result = acc | opr;
      OP_XOR: result = acc ^ opr;
      OP_NOT: result = ~acc;
      OP_INC: begin
        ext    = {1'b0, acc} + (DATA_W+1)'(1);
        result = ext[MSB:0];
        c      = ext[DATA_W];
        v      = ~acc[MSB] & result[MSB];
      end
      OP_CLR: result = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulator with operand mux, registered flags and a multi-cycle serial shifter
// behind a valid/ready handshake.
module acc_unit
  import acc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int LOAD_W = 5,
  localparam int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] src_a_in,
  input  logic [DATA_W-1:0] src_b_in,
  input  logic              src_sel,
  input  logic              op_valid,
  input  logic [3:0]        op_code,
  input  logic [SH_W-1:0]   shamt,
  output logic              op_ready,
  output logic              busy,
  output logic [DATA_W-1:0] ac_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] opr;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] shifted;
  logic              alu_c;
  logic              alu_v;
  logic              accept;
  logic              ready_q;
  logic              shift_left;
  logic [SH_W-1:0]   cnt;
  state_t            state;

  assign opr      = src_sel ? src_b_in : src_a_in;
  assign accept   = op_valid & ready_q;
  assign op_ready = ready_q;
  assign busy     = ~ready_q;
  assign ac_out   = acc;
  assign shifted  = shift_left ? {acc[MSB-1:0], 1'b0} : {1'b0, acc[MSB:1]};

  acc_alu #(
    .DATA_W(DATA_W),
    .LOAD_W(LOAD_W)
  ) u_alu (
    .acc    (acc),
    .opr    (opr),
    .op_code(op_code),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      shift_left <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op_code)
              OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC, OP_CLR: begin
                acc    <= alu_res;
                flag_z <= (alu_res == '0);
                flag_n <= alu_res[MSB];
                flag_c <= alu_c;
                flag_v <= alu_v;
              end
              OP_SHL, OP_SHR: begin
                if (shamt == '0) begin
                  flag_z <= (acc == '0);
                  flag_n <= acc[MSB];
                  flag_c <= 1'b0;
                  flag_v <= 1'b0;
                end else begin
                  state      <= ST_SHIFT;
                  cnt        <= shamt;
                  shift_left <= (op_code == OP_SHL);
                  ready_q    <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          acc    <= shifted;
          flag_c <= shift_left ? acc[MSB] : acc[0];
          flag_v <= 1'b0;
          // Z/N only settle on the final step; intermediate steps leave them stale.
          if (cnt == SH_W'(1)) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            flag_z  <= (shifted == '0);
            flag_n  <= shifted[MSB];
          end else begin
            cnt <= cnt - SH_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench for acc_unit: a reference model pushes expected per-cycle state,
// which is popped and compared on each falling edge after an op is accepted.
module tb_acc_unit;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_a_in, src_b_in;
  logic       src_sel, op_valid;
  logic [3:0] op_code;
  logic [2:0] shamt;
  logic       op_ready, busy;
  logic [7:0] ac_out;
  logic       flag_z, flag_n, flag_c, flag_v;

  acc_unit #(.DATA_W(8), .LOAD_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_a_in(src_a_in),
    .src_b_in(src_b_in),
    .src_sel (src_sel),
    .op_valid(op_valid),
    .op_code (op_code),
    .shamt   (shamt),
    .op_ready(op_ready),
    .busy    (busy),
    .ac_out  (ac_out),
    .flag_z  (flag_z),
    .flag_n  (flag_n),
    .flag_c  (flag_c),
    .flag_v  (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ac;
    logic       z, n, c, v, rdy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] m_acc;
  logic       m_z, m_n, m_c, m_v;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  task automatic sb_push(input logic rdy);
    exp_t e;
    e.ac = m_acc; e.z = m_z; e.n = m_n; e.c = m_c; e.v = m_v; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_ac"},    ac_out,   e.ac);
      check_eq({tag, "_z"},     flag_z,   e.z);
      check_eq({tag, "_n"},     flag_n,   e.n);
      check_eq({tag, "_c"},     flag_c,   e.c);
      check_eq({tag, "_v"},     flag_v,   e.v);
      check_eq({tag, "_ready"}, op_ready, e.rdy);
      check_eq({tag, "_busy"},  busy,     !e.rdy);
    end
  endtask

  // Reference model for single-cycle ops, using plain integer arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [7:0] opr);
    int   a, b, sa, so, r;
    logic c, v, upd;
    a = m_acc; b = opr; sa = $signed(m_acc); so = $signed(opr);
    c = 1'b0; v = 1'b0; upd = 1'b1; r = a;
    case (op)
      4'd1: r = b % 32;
      4'd2: begin r = a + b; c = (r > 255); v = (sa + so > 127) || (sa + so < -128); end
      4'd3: begin r = a - b; c = (a < b);   v = (sa - so > 127) || (sa - so < -128); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      4'd8: begin r = a + 1; c = (a == 255); v = (a == 127); end
      4'd9: r = 0;
      default: upd = 1'b0;
    endcase
    if (upd) begin
      m_acc = r[7:0];
      m_z = (m_acc == 8'h00);
      m_n = m_acc[7];
      m_c = c;
      m_v = v;
    end
  endtask

  task automatic model_shift_step(input logic left, input logic last);
    if (left) begin m_c = m_acc[7]; m_acc = m_acc << 1; end
    else      begin m_c = m_acc[0]; m_acc = m_acc >> 1; end
    m_v = 1'b0;
    if (last) begin m_z = (m_acc == 8'h00); m_n = m_acc[7]; end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic sel, input logic [2:0] sh);
    int n, n_obs;
    @(negedge clk);
    op_code = op; src_a_in = a; src_b_in = b; src_sel = sel; shamt = sh; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check_eq({tag, "_ready_timeout"}, 0, 1);
    if ((op == OP_SHL || op == OP_SHR) && sh != 3'd0) begin
      sb_push(1'b0);
      for (int k = 1; k <= int'(sh); k++) begin
        model_shift_step(op == OP_SHL, k == int'(sh));
        sb_push(k == int'(sh));
      end
      n_obs = int'(sh) + 1;
    end else if (op == OP_SHL || op == OP_SHR) begin
      m_z = (m_acc == 8'h00); m_n = m_acc[7]; m_c = 1'b0; m_v = 1'b0;
      sb_push(1'b1);
      n_obs = 1;
    end else begin
      model_op(op, sel ? b : a);
      sb_push(1'b1);
      n_obs = 1;
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
    for (int i = 0; i < n_obs; i++) begin
      @(negedge clk);
      sb_check($sformatf("%s_c%0d", tag, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; src_a_in = 8'h00; src_b_in = 8'h00;
    src_sel = 1'b0; shamt = 3'd0;
    model_reset();
    #12;
    check_eq("rst_ac", ac_out, 8'h00);
    check_eq("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    check_eq("rst_ready", op_ready, 1);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("ld_mask",  OP_LD,  8'h00, 8'hFF, 1'b1, 3'd0);
    run_op("add_7f",   OP_ADD, 8'h60, 8'h00, 1'b0, 3'd0);
    run_op("add_ovf",  OP_ADD, 8'h01, 8'h00, 1'b0, 3'd0);
    run_op("sub_brw",  OP_SUB, 8'h81, 8'h00, 1'b0, 3'd0);
    run_op("inc_wrap", OP_INC, 8'h00, 8'h00, 1'b0, 3'd0);
    run_op("op_f",     4'hF,   8'h55, 8'hAA, 1'b0, 3'd5);
    run_op("nop",      OP_NOP, 8'h55, 8'hAA, 1'b1, 3'd0);
    run_op("ld_01",    OP_LD,  8'h01, 8'h00, 1'b0, 3'd0);
    run_op("or_81",    OP_OR,  8'h80, 8'h00, 1'b0, 3'd0);
    run_op("shl3",     OP_SHL, 8'h00, 8'h00, 1'b0, 3'd3);
    run_op("sub_ff",   OP_SUB, 8'h09, 8'h00, 1'b0, 3'd0);
    run_op("shl0",     OP_SHL, 8'h00, 8'h00, 1'b0, 3'd0);
    run_op("xor",      OP_XOR, 8'h0F, 8'h00, 1'b0, 3'd0);
    run_op("and_b",    OP_AND, 8'h00, 8'h3C, 1'b1, 3'd0);
    run_op("not",      OP_NOT, 8'h00, 8'h00, 1'b0, 3'd0);

    // SHR by 2 with an ADD held on the bus while busy.
    @(negedge clk);
    op_code = OP_SHR; shamt = 3'd2; src_sel = 1'b0; src_a_in = 8'h05; op_valid = 1'b1;
    sb_push(1'b0);
    model_shift_step(1'b0, 1'b0); sb_push(1'b0);
    model_shift_step(1'b0, 1'b1); sb_push(1'b1);
    model_op(OP_ADD, 8'h05);      sb_push(1'b1);
    @(posedge clk);
    #1 op_code = OP_ADD;
    @(negedge clk); sb_check("hs_c0");
    @(negedge clk); sb_check("hs_c1");
    @(negedge clk); sb_check("hs_c2");
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk); sb_check("hs_add");

    run_op("clr", OP_CLR, 8'h00, 8'h00, 1'b0, 3'd0);
    run_op("ld_11", OP_LD, 8'h11, 8'h00, 1'b0, 3'd0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    op_code = OP_SHL; shamt = 3'd5; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ac", ac_out, 8'h00);
    check_eq("midrst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    check_eq("midrst_ready", op_ready, 1);
    model_reset();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("post_rst_ac", ac_out, 8'h00);
    check_eq("post_rst_ready", op_ready, 1);
    run_op("ld_after", OP_LD, 8'h0A, 8'h00, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
